// File: rtl/seq_detect_param.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_param
// Brief    : Serial pattern detector for a runtime-loadable LEN-bit pattern,
//            with selectable overlapping / restart-after-match behaviour.
//            Optional saturating match counter when SEQDET_COUNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module seq_detect_param #(
  parameter int LEN   = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             cfg_load,
  input  logic [LEN-1:0]   cfg_pattern,
  input  logic             cfg_overlap,
  output logic             armed,
  output logic             match,
  output logic [CNT_W-1:0] match_count
);

  localparam int c_fill_w = $clog2(LEN + 1);

  localparam logic [0:0] c_idle = 1'b0;
  localparam logic [0:0] c_hunt = 1'b1;

  localparam logic [c_fill_w-1:0] c_len    = c_fill_w'(LEN);
  localparam logic [c_fill_w-1:0] c_len_m1 = c_fill_w'(LEN - 1);

  logic [0:0]          r_state;
  logic [LEN-1:0]      r_pattern;
  // Only the newest LEN-1 history bits can ever reach a candidate word.
  logic [LEN-2:0]      r_hist;
  logic [c_fill_w-1:0] r_fill;
  logic                r_match;

  logic [LEN-1:0]      w_cand;
  logic                w_hit;

  assign w_cand = {r_hist, in_bit};
  assign w_hit  = (r_fill >= c_len_m1) && (w_cand == r_pattern);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= c_idle;
      r_pattern <= '0;
      r_hist    <= '0;
      r_fill    <= '0;
      r_match   <= 1'b0;
    end else begin
      r_match <= 1'b0;
      if (cfg_load) begin
        r_state   <= c_hunt;
        r_pattern <= cfg_pattern;
        r_hist    <= '0;
        r_fill    <= '0;
      end else if ((r_state == c_hunt) && in_valid) begin
        r_hist  <= w_cand[LEN-2:0];
        r_match <= w_hit;
        if (w_hit && !cfg_overlap) begin
          r_fill <= '0;
        end else if (r_fill != c_len) begin
          r_fill <= r_fill + 1'b1;
        end
      end
    end
  end

  assign armed = (r_state == c_hunt);
  assign match = r_match;

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] r_count;

  // Counts registered pulses; sticks at all-ones until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (r_match && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign match_count = r_count;
`else
  assign match_count = '0;
`endif

endmodule
`default_nettype wire
